// File: rtl/rmii_pkg.sv
// Shared RMII constants and the transmit state encoding, used by the tx and rx paths.
package rmii_pkg;

  localparam int DEF_PREAMBLE_BYTES = 7;
  localparam int DEF_IFG_BYTES      = 12;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [7:0] SFD_BYTE       = 8'hD5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PREAMBLE,
    TX_SFD,
    TX_DATA,
    TX_IFG
  } tx_state_e;

  // Dibit idx of the SFD byte, LSb dibit first as it goes on the wire.
  function automatic logic [1:0] sfd_dibit(input logic [1:0] idx);
    logic [7:0] b;
    b = SFD_BYTE;
    return b[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/rmii_tx_serializer_if.sv
// Payload byte stream into the RMII transmit serializer (valid/ready, last-flagged).
interface rmii_tx_serializer_if;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axiilast;
  logic       axiir;

  modport master (output axiiv, output axiid, output axiilast, input axiir);
  modport slave  (input axiiv, input axiid, input axiilast, output axiir);
endinterface

// File: rtl/rmii_tx_serializer.sv
// RMII transmit serializer: preamble + SFD + payload bytes as dibits, LSb first,
// followed by an enforced inter-frame gap. One dibit per clock.
module rmii_tx_serializer
  import rmii_pkg::*;
#(
  parameter int PREAMBLE_BYTES = DEF_PREAMBLE_BYTES,
  parameter int IFG_BYTES      = DEF_IFG_BYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rmii_tx_serializer_if.slave  s,
  output logic                 txen,
  output logic [1:0]           txd,
  output logic                 busy,
  output logic                 underrun
);

  localparam int BMAX = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
  localparam int BCW  = $clog2(BMAX + 1);

  tx_state_e        state_q, state_d;
  logic [1:0]       dib_q, dib_d;
  logic [BCW-1:0]   byte_q, byte_d;
  logic [7:0]       sh_q, sh_d;
  logic             last_q, last_d;
  logic             txen_q, txen_d;
  logic [1:0]       txd_q, txd_d;
  logic             rdy, urun, load_pt;

  // The state always describes the dibit currently on the wire; txen/txd
  // registers therefore capture the dibit belonging to the next cycle.
  assign load_pt = (dib_q == 2'd3) &&
                   ((state_q == TX_SFD) || ((state_q == TX_DATA) && !last_q));

  // Next-state, counters, shift register and next wire dibit.
  always_comb begin
    state_d = state_q;
    dib_d   = dib_q + 2'd1;
    byte_d  = byte_q;
    sh_d    = sh_q;
    last_d  = last_q;
    txen_d  = 1'b0;
    txd_d   = 2'b00;
    rdy     = 1'b0;
    urun    = 1'b0;

    case (state_q)
      TX_IDLE: begin
        dib_d  = '0;
        byte_d = '0;
        last_d = 1'b0;
        if (s.axiiv) begin
          state_d = TX_PREAMBLE;
          txen_d  = 1'b1;
          txd_d   = PREAMBLE_DIBIT;
        end
      end
      TX_PREAMBLE: begin
        // Last preamble byte rolls straight into the SFD; its first dibit is also 01.
        txen_d = 1'b1;
        txd_d  = PREAMBLE_DIBIT;
        if (dib_q == 2'd3) begin
          if (byte_q == BCW'(PREAMBLE_BYTES - 1)) begin
            state_d = TX_SFD;
            byte_d  = '0;
          end else begin
            byte_d = byte_q + BCW'(1);
          end
        end
      end
      TX_SFD: begin
        if (dib_q != 2'd3) begin
          txen_d = 1'b1;
          txd_d  = sfd_dibit(dib_q + 2'd1);
        end
      end
      TX_DATA: begin
        if (dib_q != 2'd3) begin
          txen_d = 1'b1;
          txd_d  = sh_q[1:0];
          sh_d   = {2'b00, sh_q[7:2]};
        end else if (last_q) begin
          state_d = TX_IFG;
          byte_d  = '0;
        end
      end
      TX_IFG: begin
        if (dib_q == 2'd3) begin
          if (byte_q == BCW'(IFG_BYTES - 1)) begin
            state_d = TX_IDLE;
            byte_d  = '0;
          end else begin
            byte_d = byte_q + BCW'(1);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Byte boundary: either a new byte is taken (its first dibit goes out next
    // cycle, so there is no gap) or the frame is cut short for lack of data.
    if (load_pt) begin
      rdy = 1'b1;
      if (s.axiiv) begin
        state_d = TX_DATA;
        txen_d  = 1'b1;
        txd_d   = s.axiid[1:0];
        sh_d    = {2'b00, s.axiid[7:2]};
        last_d  = s.axiilast;
      end else begin
        urun    = 1'b1;
        state_d = TX_IFG;
        byte_d  = '0;
      end
    end
  end

  // State, counters and registered RMII outputs; reset truncates any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      dib_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      txen_q  <= 1'b0;
      txd_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      dib_q   <= dib_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
    end
  end

  assign s.axiir  = rdy;
  assign txen     = txen_q;
  assign txd      = txd_q;
  assign busy     = (state_q != TX_IDLE);
  assign underrun = urun;

endmodule
